// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The ALU decoder also uses the ALUC_* codes.
package muldiv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFin
  } muldiv_state_t;

  localparam logic [3:0]  ALUC_MULT    = 4'b1010;
  localparam logic [3:0]  ALUC_DIV     = 4'b1011;
  localparam int unsigned MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_if.sv
// Command/result bundle between the execute stage and muldiv_unit.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       alucontrol;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alucontrol, srca, srcb,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, alucontrol, srca, srcb,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Combinational two's-complement conditional negate.
module muldiv_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);
  assign out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit writing HI/LO.
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus_io
);

  muldiv_state_t state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               is_mult, is_div, accept, last_iter;

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_a (
    .in_i  (bus_io.srca),
    .neg_i (bus_io.srca[WIDTH-1]),
    .out_o (mag_a)
  );

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_b (
    .in_i  (bus_io.srcb),
    .neg_i (bus_io.srcb[WIDTH-1]),
    .out_o (mag_b)
  );

  muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .in_i  (acc_q),
    .neg_i (sign_a_q ^ sign_b_q),
    .out_o (prod_fix)
  );

  // Product lives in acc_q: upper half accumulates, lower half holds the shifting multiplier.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  assign is_mult   = (bus_io.alucontrol == ALUC_MULT);
  assign last_iter = (cnt_q == 6'(MULDIV_ITERS - 1));

`ifdef MULDIV_DIV_EN
  logic               op_div_q, op_div_d;
  logic               div0_q, div0_d;
  logic [WIDTH:0]     rem_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_div = (bus_io.alucontrol == ALUC_DIV);

  // Restoring step: acc_q = {remainder, dividend bits shifting into quotient}.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
    .in_i  (acc_q[WIDTH-1:0]),
    .neg_i (sign_a_q ^ sign_b_q),
    .out_o (quo_fix)
  );

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
    .in_i  (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i (sign_a_q),
    .out_o (rem_fix)
  );
`else
  assign is_div = 1'b0;
`endif

  assign accept = bus_io.start && (is_mult || is_div);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef MULDIV_DIV_EN
    op_div_d = op_div_q;
    div0_d   = div0_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d    = '0;
          sign_a_d = bus_io.srca[WIDTH-1];
          sign_b_d = bus_io.srcb[WIDTH-1];
          busy_d   = 1'b1;
          // Multiply adds |srca| into the product; divide subtracts |srcb|.
          opnd_d   = is_div ? mag_b : mag_a;
          acc_d    = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          state_d  = is_div ? StDiv : StMul;
`ifdef MULDIV_DIV_EN
          op_div_d = is_div;
          div0_d   = (bus_io.srcb == '0);
`endif
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 6'd1;
        if (last_iter) state_d = StFin;
      end
`ifdef MULDIV_DIV_EN
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + 6'd1;
        if (last_iter) state_d = StFin;
      end
`endif
      StFin: begin
`ifdef MULDIV_DIV_EN
        if (op_div_q) begin
          // With a zero divisor the remainder path already reproduces srca.
          hi_d = rem_fix;
          lo_d = div0_q ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
`else
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
`endif
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div_q <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MULDIV_DIV_EN
      op_div_q <= op_div_d;
      div0_q   <= div0_d;
`endif
    end
  end

  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;
  assign bus_io.hi   = hi_q;
  assign bus_io.lo   = lo_q;

endmodule
